// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and constants for the seven-segment scan display.
//   state_e   : scan FSM states (digit lit / inter-digit blanking gap)
//   SEG_BLANK : all segments off (active low)
//   AN_OFF    : all anodes off (active low)
//   HEX_SEG   : hex nibble -> {g,f,e,d,c,b,a} active-low segment pattern
package seg7_pkg;

    typedef enum logic {
        StShow  = 1'b0,
        StBlank = 1'b1
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Entry n sits at HEX_SEG[n]; listed from F down to 0.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low seven-segment decoder.
//   nibble_i : 4-bit hex digit
//   seg_o    : {g,f,e,d,c,b,a}, active low
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: latches a 16-bit debug value and time-multiplexes it onto a
// 4-digit common-anode seven-segment display, with an all-off gap between digits.
//   BasysCLK : board clock, all logic on its rising edge
//   Reset    : asynchronous, active-high reset
//   Load     : single-cycle strobe capturing Value/DotMask
//   Value    : 16-bit hex value, nibble i -> digit i (digit 0 rightmost)
//   DotMask  : bit i lights the decimal point of digit i
//   AN       : digit anodes, active low
//   SEG      : segments {g,f,e,d,c,b,a}, active low
//   DP       : decimal point, active low
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN: blank the segments of digits
// above digit 0 whose nibble and all higher nibbles are zero.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic        BasysCLK,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] Value,
    input  logic [3:0]  DotMask,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    // With no blanking the BLANK state is never entered; keep its limit in range.
    localparam int unsigned BlankLast = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
    localparam logic [CNT_W-1:0] ShowTc  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BlankTc = CNT_W'(BlankLast);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [15:0]        value_q;
    logic [3:0]         dots_q;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic [3:0]         nibble;
    logic [6:0]         seg_dec;
    logic               lz_blank;

    // Scan state and latched value.
    always_ff @(posedge BasysCLK or posedge Reset) begin
        if (Reset) begin
            state_q <= StShow;
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            value_q <= 16'h0000;
            dots_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (Load) begin
                value_q <= Value;
                dots_q  <= DotMask;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        unique case (state_q)
            StShow: begin
                if (cnt_q == ShowTc) begin
                    cnt_d = '0;
                    if (BLANK_CYCLES == 0) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        state_d = StBlank;
                    end
                end
            end
            StBlank: begin
                if (cnt_q == BlankTc) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = StShow;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StShow;
            end
        endcase
    end

    assign nibble = value_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble_i (nibble),
        .seg_o    (seg_dec)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit 0 always shows, so a zero value still displays "0".
    assign lz_blank = (idx_q != 2'd0) && ((value_q >> {idx_q, 2'b00}) == 16'h0000);
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (state_q == StShow) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank ? SEG_BLANK : seg_dec;
            dp_d  = ~dots_q[idx_q];
        end
    end

    // Registered outputs keep the pins glitch-free; they lag the scan state by a cycle.
    always_ff @(posedge BasysCLK or posedge Reset) begin
        if (Reset) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign AN  = an_q;
    assign SEG = seg_q;
    assign DP  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dots;
    logic [3:0]  an_a, an_b;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;

    int tests = 0;
    int fails = 0;
    int ec    = 0;
    bit chk_en = 0;

    // DUT with blanking gap, and a second one with no blanking.
    seg7_scan_display #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2),
        .CNT_W        (4)
    ) dut (
        .BasysCLK (clk),
        .Reset    (rst),
        .Load     (load),
        .Value    (value),
        .DotMask  (dots),
        .AN       (an_a),
        .SEG      (seg_a),
        .DP       (dp_a)
    );

    seg7_scan_display #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (0),
        .CNT_W        (4)
    ) dut_nb (
        .BasysCLK (clk),
        .Reset    (rst),
        .Load     (load),
        .Value    (value),
        .DotMask  (dots),
        .AN       (an_b),
        .SEG      (seg_b),
        .DP       (dp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Display seen at scan position p (cycles since reset): each digit owns r+b
    // cycles, lit for the first r of them.
    function automatic logic [11:0] model_out(input int p, input int r, input int b,
                                              input logic [15:0] v, input logic [3:0] d);
        int slot;
        int dig;
        logic [15:0] hi;
        logic [3:0]  an;
        logic [6:0]  sg;
        slot = p % (r + b);
        dig  = (p / (r + b)) % 4;
        if (slot >= r) return {4'b1111, 7'b1111111, 1'b1};
        hi = v >> (4 * dig);
        an = 4'b1111;
        an[dig] = 1'b0;
        sg = hex7(hi[3:0]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (dig > 0 && hi == 16'h0000) sg = 7'b1111111;
`endif
        return {an, sg, ~d[dig]};
    endfunction

    int          m_p;
    logic [15:0] m_val;
    logic [3:0]  m_dots;
    logic [11:0] exp_a, exp_b;

    // Outputs after an edge reflect the position and latched value before it.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_p    <= 0;
            m_val  <= 16'h0000;
            m_dots <= 4'b0000;
            exp_a  <= {4'b1111, 7'b1111111, 1'b1};
            exp_b  <= {4'b1111, 7'b1111111, 1'b1};
        end else begin
            exp_a <= model_out(m_p, 4, 2, m_val, m_dots);
            exp_b <= model_out(m_p, 4, 0, m_val, m_dots);
            m_p   <= m_p + 1;
            if (load) begin
                m_val  <= value;
                m_dots <= dots;
            end
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic check_onehot(input string name, input logic [3:0] an);
        tests++;
        if ($countones(~an) > 1) begin
            fails++;
            $display("FAIL %s: got an=%b, want at most one low bit", name, an);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_blank2", {an_a, seg_a, dp_a}, exp_a);
            check("model_blank0", {an_b, seg_b, dp_b}, exp_b);
            check_onehot("onehot_blank2", an_a);
            check_onehot("onehot_blank0", an_b);
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
        ec += n;
    endtask

    task automatic wait_an(input logic [3:0] target);
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            ec++;
            if (an_a == target) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_an: got an=%b, want an=%b within 40 cycles", an_a, target);
        end
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        dots  = 4'b0000;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("reset_state", {an_a, seg_a, dp_a}, {4'b1111, 7'b1111111, 1'b1});

        // Release reset and load 12AF with the dot on digit 2.
        rst   = 1'b0;
        load  = 1'b1;
        value = 16'h12AF;
        dots  = 4'b0100;
        ec    = 0;
        adv(1);
        load = 1'b0;
        adv(1);
        check("digit0_F", {an_a, seg_a, dp_a}, {4'b1110, 7'b0001110, 1'b1});
        adv(3);
        check("gap_0_1", {an_a, seg_a, dp_a}, {4'b1111, 7'b1111111, 1'b1});
        check("nb_digit1", {an_b, seg_b, dp_b}, {4'b1101, 7'b0001000, 1'b1});
        adv(2);
        check("digit1_A", {an_a, seg_a, dp_a}, {4'b1101, 7'b0001000, 1'b1});
        adv(2);
        check("nb_digit2", {an_b, seg_b, dp_b}, {4'b1011, 7'b0100100, 1'b0});
        adv(4);
        check("digit2_2dp", {an_a, seg_a, dp_a}, {4'b1011, 7'b0100100, 1'b0});
        check("nb_digit3", {an_b, seg_b, dp_b}, {4'b0111, 7'b1111001, 1'b1});
        adv(6);
        check("digit3_1", {an_a, seg_a, dp_a}, {4'b0111, 7'b1111001, 1'b1});
        adv(6);
        check("wrap_digit0", {an_a, seg_a, dp_a}, {4'b1110, 7'b0001110, 1'b1});

        // Mid-slot load while digit 0 is lit.
        load  = 1'b1;
        value = 16'h0003;
        dots  = 4'b0000;
        adv(1);
        load = 1'b0;
        adv(1);
        check("midslot_load", {an_a, seg_a, dp_a}, {4'b1110, 7'b0110000, 1'b1});

        // Leading-zero value.
        load  = 1'b1;
        value = 16'h0050;
        dots  = 4'b0000;
        adv(1);
        load = 1'b0;
        adv(3);
        wait_an(4'b0111);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        check("lz_digit3", {an_a, seg_a, dp_a}, {4'b0111, 7'b1111111, 1'b1});
`else
        check("lz_digit3", {an_a, seg_a, dp_a}, {4'b0111, 7'b1000000, 1'b1});
`endif
        wait_an(4'b1101);
        check("lz_digit1", {an_a, seg_a, dp_a}, {4'b1101, 7'b0010010, 1'b1});
        wait_an(4'b1110);
        check("lz_digit0", {an_a, seg_a, dp_a}, {4'b1110, 7'b1000000, 1'b1});

        // Asynchronous reset mid-scan while digit 1 is lit.
        wait_an(4'b1101);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", {an_a, seg_a, dp_a}, {4'b1111, 7'b1111111, 1'b1});
        check("async_reset_nb", {an_b, seg_b, dp_b}, {4'b1111, 7'b1111111, 1'b1});
        @(negedge clk);
        rst = 1'b0;
        adv(1);
        check("first_after_reset", {an_a, seg_a, dp_a}, {4'b1110, 7'b1000000, 1'b1});

        // Random loads, including values with leading zeros.
        for (int i = 0; i < 3000; i++) begin
            load  = ($urandom % 8) == 0;
            value = 16'($urandom >> ($urandom % 32));
            dots  = 4'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        @(negedge clk);
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
